// File: rtl/muldiv_issue_ctrl_if.sv
// Signal bundle between the mul/div issue controller and the EX stage, the shared
// mul/div responder and the regfile writeback port.
interface muldiv_issue_ctrl_if #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NUM_HARTS  = 4,
    parameter int unsigned HART_ID_W  = 2,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned OP_W       = 3
);
    logic                  req_valid;
    logic                  req_ready;
    logic [OP_W-1:0]       req_op;
    logic [XLEN-1:0]       req_a;
    logic [XLEN-1:0]       req_b;
    logic [HART_ID_W-1:0]  req_hart_id;
    logic [REG_ADDR_W-1:0] req_rd;

    logic                  md_start;
    logic [OP_W-1:0]       md_op;
    logic [XLEN-1:0]       md_a;
    logic [XLEN-1:0]       md_b;
    logic [HART_ID_W-1:0]  md_hart_id;
    logic [REG_ADDR_W-1:0] md_rd;
    logic                  md_busy;
    logic                  md_done;
    logic [XLEN-1:0]       md_result;
    logic [HART_ID_W-1:0]  md_done_hart_id;
    logic [REG_ADDR_W-1:0] md_done_rd;

    logic                  wb_valid;
    logic                  wb_ready;
    logic [XLEN-1:0]       wb_data;
    logic [HART_ID_W-1:0]  wb_hart_id;
    logic [REG_ADDR_W-1:0] wb_rd;

    logic [NUM_HARTS-1:0]  hart_pending;
    logic                  err;

    // master is the issue controller; slave is everything around it
    modport master (
        input  req_valid, req_op, req_a, req_b, req_hart_id, req_rd,
        input  md_busy, md_done, md_result, md_done_hart_id, md_done_rd,
        input  wb_ready,
        output req_ready,
        output md_start, md_op, md_a, md_b, md_hart_id, md_rd,
        output wb_valid, wb_data, wb_hart_id, wb_rd,
        output hart_pending, err
    );

    modport slave (
        output req_valid, req_op, req_a, req_b, req_hart_id, req_rd,
        output md_busy, md_done, md_result, md_done_hart_id, md_done_rd,
        output wb_ready,
        input  req_ready,
        input  md_start, md_op, md_a, md_b, md_hart_id, md_rd,
        input  wb_valid, wb_data, wb_hart_id, wb_rd,
        input  hart_pending, err
    );
endinterface

// File: rtl/muldiv_issue_ctrl.sv
// Multi-hart mul/div initiator: in-order request FIFO, single-op issue to the shared
// responder, one-entry writeback buffer, per-hart pending scoreboard and sticky error.
module muldiv_issue_ctrl #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NUM_HARTS  = 4,
    parameter int unsigned HART_ID_W  = 2,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned OP_W       = 3
) (
    input logic                 clk,
    input logic                 rst_n,
    muldiv_issue_ctrl_if.master bus
);
    localparam int unsigned IDX_W = $clog2(NUM_HARTS);
    localparam int unsigned PTR_W = IDX_W + 1;

    typedef struct packed {
        logic [OP_W-1:0]       op;
        logic [XLEN-1:0]       a;
        logic [XLEN-1:0]       b;
        logic [HART_ID_W-1:0]  hart;
        logic [REG_ADDR_W-1:0] rd;
    } entry_t;

    entry_t                fifo_mem [NUM_HARTS];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic                  inflight_q;
    logic [HART_ID_W-1:0]  iss_hart_q;
    logic [REG_ADDR_W-1:0] iss_rd_q;
    logic                  wb_valid_q;
    logic [XLEN-1:0]       wb_data_q;
    logic [HART_ID_W-1:0]  wb_hart_q;
    logic [REG_ADDR_W-1:0] wb_rd_q;
    logic [NUM_HARTS-1:0]  pending_q;
    logic [NUM_HARTS-1:0]  pending_d;
    logic                  err_q;

    logic   fifo_empty;
    logic   fifo_full;
    logic   req_ready_c;
    logic   md_start_c;
    logic   push;
    logic   wb_fire;
    logic   done_ok;
    logic   done_bad;
    entry_t head;

    // Handshake decode; pending is the registered copy so a same-cycle writeback
    // never lets the same hart back in early.
    always_comb begin
        fifo_empty  = (wr_ptr_q == rd_ptr_q);
        fifo_full   = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                      (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
        head        = fifo_mem[rd_ptr_q[IDX_W-1:0]];
        req_ready_c = !fifo_full && !pending_q[bus.req_hart_id];
        push        = bus.req_valid && req_ready_c;
        wb_fire     = wb_valid_q && bus.wb_ready;
        md_start_c  = !fifo_empty && !inflight_q && !bus.md_busy && (!wb_valid_q || bus.wb_ready);
        done_ok     = bus.md_done && inflight_q;
        done_bad    = (bus.md_done && !inflight_q) ||
                      (done_ok && ((bus.md_done_hart_id != iss_hart_q) || (bus.md_done_rd != iss_rd_q)));
    end

    // Writeback clears the draining hart, accept marks the requesting one
    always_comb begin
        pending_d = pending_q;
        if (wb_fire) pending_d[wb_hart_q] = 1'b0;
        if (push)    pending_d[bus.req_hart_id] = 1'b1;
    end

    // FIFO storage carries no reset; only the pointers define occupancy
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[IDX_W-1:0]] <= '{op:   bus.req_op,
                                              a:    bus.req_a,
                                              b:    bus.req_b,
                                              hart: bus.req_hart_id,
                                              rd:   bus.req_rd};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= 1'b0;
            iss_hart_q <= '0;
            iss_rd_q   <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_hart_q  <= '0;
            wb_rd_q    <= '0;
            pending_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            pending_q <= pending_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (md_start_c) begin
                rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
                iss_hart_q <= head.hart;
                iss_rd_q   <= head.rd;
            end
            if (md_start_c)   inflight_q <= 1'b1;
            else if (done_ok) inflight_q <= 1'b0;
            // A result landing during a drain reloads the buffer and keeps it valid
            if (done_ok) begin
                wb_valid_q <= 1'b1;
                wb_data_q  <= bus.md_result;
                wb_hart_q  <= bus.md_done_hart_id;
                wb_rd_q    <= bus.md_done_rd;
            end else if (wb_fire) begin
                wb_valid_q <= 1'b0;
            end
            if (done_bad) err_q <= 1'b1;
        end
    end

    assign bus.req_ready    = req_ready_c;
    assign bus.md_start     = md_start_c;
    assign bus.md_op        = head.op;
    assign bus.md_a         = head.a;
    assign bus.md_b         = head.b;
    assign bus.md_hart_id   = head.hart;
    assign bus.md_rd        = head.rd;
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.wb_hart_id   = wb_hart_q;
    assign bus.wb_rd        = wb_rd_q;
    assign bus.hart_pending = pending_q;
    assign bus.err          = err_q;
endmodule

// File: doc/muldiv_issue_ctrl.md
Name: muldiv_issue_ctrl

Overview:
- Initiator side of the multi-hart mul/div request/response interface.
- Accepts M-extension ops from the EX stage for any hart and queues them in order.
- Issues exactly one op at a time to the shared multi-cycle mul/div responder.
- Returns each result through a single-entry writeback buffer with a valid/ready handshake, and keeps a per-hart pending scoreboard for stall logic.

Parameters:
XLEN, 32, operand/result width
NUM_HARTS, 4, hart count; also request FIFO depth
HART_ID_W, 2, hart id width (clog2 NUM_HARTS)
REG_ADDR_W, 5, destination register index width
OP_W, 3, mul/div opcode width (8 ops: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
req_valid  in  1  EX-stage request valid
req_ready  out  1  request accepted when valid&ready
req_op  in  OP_W  opcode
req_a  in  XLEN  rs1 value
req_b  in  XLEN  rs2 value
req_hart_id  in  HART_ID_W  issuing hart
req_rd  in  REG_ADDR_W  destination register
md_start  out  1  one-cycle start to responder
md_op, md_a, md_b, md_hart_id, md_rd  out  OP_W/XLEN/XLEN/HART_ID_W/REG_ADDR_W  payload, valid only with md_start
md_busy  in  1  responder busy
md_done  in  1  one-cycle result pulse
md_result  in  XLEN  result
md_done_hart_id  in  HART_ID_W  result hart
md_done_rd  in  REG_ADDR_W  result rd
wb_valid  out  1  writeback buffer full
wb_ready  in  1  regfile port grants writeback
wb_data  out  XLEN  result
wb_hart_id  out  HART_ID_W  result hart
wb_rd  out  REG_ADDR_W  result rd
hart_pending  out  NUM_HARTS  bit h set = hart h has an op accepted but not yet written back
err  out  1  sticky protocol error

Behaviour:
- Reset: clk and rst_n as decided above — reset rst_n, asynchronous, active-low; clock clk.
  - Reset clears the FIFO, inflight, the wb buffer, hart_pending and err.
  - Combinational outputs at reset: req_ready=1, md_start=0, wb_valid=0, wb_data/wb_hart_id/wb_rd=0.
  - Reset mid-operation drops all queued and inflight ops with no writeback; the responder shares rst_n.
- Accept:
  - req_ready = !fifo_full && !hart_pending[req_hart_id], using registered pending.
  - On accept, push {op,a,b,hart,rd} and set hart_pending[req_hart_id].
  - At most one outstanding op per hart, so the FIFO never overflows; fifo_full is kept as a guard.
- Issue:
  - md_start = fifo_nonempty && !inflight && !md_busy && (!wb_valid || wb_ready).
  - md_start is combinational, and the payload comes directly from the FIFO head.
  - On md_start, pop the head and set inflight.
  - Earliest md_start is the cycle after accept; there is no bypass.
  - Ops issue in strict acceptance order.
- Inflight:
  - Set by md_start; cleared by md_done.
  - Only one op is ever outstanding at the responder.
- Completion:
  - On md_done while inflight, capture result, hart id and rd into the wb buffer; wb_valid=1 next cycle.
  - The issue rule guarantees the buffer is free or draining when md_done arrives.
  - md_done can arrive as early as the cycle after md_start (div-by-zero/overflow fast path).
- Writeback:
  - On wb_valid && wb_ready, clear wb_valid and hart_pending[wb_hart_id].
  - A wb handshake and md_done in the same cycle: the buffer reloads with the new result and wb_valid stays 1.
  - A wb handshake and a new accept for the same hart in the same cycle: the accept is refused (registered pending), and the hart is accepted the following cycle.
  - Accept and pop in the same cycle: FIFO count is unchanged.
- FIFO:
  - Depth NUM_HARTS, with pointers one bit wider than the index for full/empty.
  - Pointers wrap modulo 2*NUM_HARTS.
- Errors: err goes high the next cycle and stays high until reset on any of:
  - md_done while !inflight (the result is ignored);
  - md_done_hart_id/md_done_rd not matching the issued hart/rd (the result is still written back).
- Widths: all payload is passed through unmodified; no arithmetic is done in this block.

Test Plan:
- Single MUL, hart 1, a=7, b=6, rd=5, wb_ready=1, responder model with 4-cycle latency:
  - md_start the cycle after accept;
  - wb_valid with data=42, hart 1, rd 5;
  - hart_pending[1] 1→0 on the wb handshake.
- Four harts request back-to-back (DIVU 100/7, REMU 100/7, MULHU 0xFFFFFFFF×2, MUL 3×3):
  - all four accepted;
  - starts serialized, never during busy;
  - wb order and data are 14, 2, 1, 9.
- Hart 2 re-requests while pending:
  - req_ready=0 until the cycle after its wb handshake, then the request is accepted.
- wb_ready held 0 for 10 cycles with a second op queued:
  - no md_start while wb_valid && !wb_ready;
  - the second op starts in the cycle wb_ready rises.
- DIV by zero with a 1-cycle responder (md_done the cycle after start) plus a simultaneous wb drain:
  - wb reloads with 0xFFFFFFFF;
  - no result is lost and err=0.
- Spurious md_done with the unit idle:
  - err=1 sticky and no wb_valid.
- Reset asserted mid-DIV:
  - all outputs return to reset values;
  - hart_pending=0 and no writeback afterwards.
